sine_maker: RTL and testbench

SINE_MAKER -- requirements
Module: sine_maker

---
 rtl/sine_maker_pkg.sv | 30 +++
 rtl/sine_maker_if.sv | 11 +
 rtl/sine_rom.sv | 28 ++
 rtl/sine_maker.sv | 33 +++
 tb/tb_sine_maker.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sine_maker_pkg.sv
// Shared constants for the sine generator:
// widths, midscale and the quarter-wave table.
package sine_maker_pkg;

    localparam int PHASE_W = 8;
    localparam int DATA_W  = 8;
    localparam logic [7:0] MID = 8'd128;

    // round(127*sin(2*pi*i/256)), i = 0..64
    localparam logic [6:0] QTAB [0:64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,
        7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,
        7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,
        7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,
        7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,
        7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111,
        7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121,
        7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126,
        7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

endpackage

// File: rtl/sine_maker_if.sv
// Phase-index to sample lookup bus between the
// phase register and the sine table.
interface sine_maker_if;

    logic [7:0] idx;
    logic [7:0] sample;

    modport master (output idx, input sample);
    modport slave  (input idx, output sample);

endinterface

// File: rtl/sine_rom.sv
// Combinational sine lookup: folds the 8-bit phase
// into a quarter-wave index and applies sign/offset.
module sine_rom
    import sine_maker_pkg::*;
(
    sine_maker_if.slave bus
);

    logic [1:0] quad;
    logic [5:0] r;
    logic [6:0] qi;
    logic [6:0] qv;

    always_comb begin
        quad = bus.idx[7:6];
        r    = bus.idx[5:0];
        // odd quadrants run the table backwards
        if (quad[0])
            qi = 7'd64 - {1'b0, r};
        else
            qi = {1'b0, r};
        qv = QTAB[qi];
    end

    assign bus.sample = quad[1] ? (MID - {1'b0, qv})
                                : (MID + {1'b0, qv});

endmodule

// File: rtl/sine_maker.sv
// Free-running sine generator: phase accumulator
// plus registered sample output.
module sine_maker
    import sine_maker_pkg::*;
#(
    parameter int STEP   = 1,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [DATA_W-1:0] data
);

    logic [PHASE_W-1:0] p;
    sine_maker_if       rom_bus ();

    assign rom_bus.idx = p;

    sine_rom u_rom (
        .bus (rom_bus)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            p    <= '0;
            data <= MID;
        end else begin
            p    <= p + PHASE_W'(STEP);
            data <= rom_bus.sample;
        end
    end

endmodule

// File: tb/tb_sine_maker.sv
// Bench for sine_maker: vector table, scoreboard queue,
// reset/step corner sequences and full table sweep.
module tb_sine_maker;

    logic       Clk;
    logic       Rst1;
    logic       Rst2;
    logic [7:0] data1;
    logic [7:0] data2;

    sine_maker_if rbus ();

    sine_maker #(.STEP(1), .DATA_W(8)) dut1 (
        .Clk  (Clk),
        .Rst  (Rst1),
        .data (data1)
    );

    sine_maker #(.STEP(64), .DATA_W(8)) dut2 (
        .Clk  (Clk),
        .Rst  (Rst2),
        .data (data2)
    );

    sine_rom u_rom (
        .bus (rbus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks;
    int n_fail;
    int sb1[$];
    int sb2[$];
    int samp[0:256];

    typedef struct {
        bit rst;
        int exp;
    } vec_t;

    typedef struct {
        int k;
        int exp;
    } spot_t;

    function automatic int s_ref(int k);
        real v;
        int  q;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0);
        if (v >= 0.0)
            q = int'($floor(v + 0.5));
        else
            q = -int'($floor(-v + 0.5));
        return 128 + q;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick1(string nm, bit r, int exp);
        int e;
        Rst1 = r;
        sb1.push_back(exp);
        @(posedge Clk);
        #1;
        e = sb1.pop_front();
        check(nm, int'(data1), e);
    endtask

    task automatic tick2(string nm, bit r, int exp);
        int e;
        Rst2 = r;
        sb2.push_back(exp);
        @(posedge Clk);
        #1;
        e = sb2.pop_front();
        check(nm, int'(data2), e);
    endtask

    vec_t  vecs[7];
    spot_t spots[6];
    int    s2exp[8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Rst1     = 1'b1;
        Rst2     = 1'b1;
        rbus.idx = 8'd0;

        vecs[0] = '{1'b1, 128};
        vecs[1] = '{1'b1, 128};
        vecs[2] = '{1'b1, 128};
        vecs[3] = '{1'b0, 128};
        vecs[4] = '{1'b0, 131};
        vecs[5] = '{1'b0, 134};
        vecs[6] = '{1'b0, 137};

        spots[0] = '{32, 218};
        spots[1] = '{64, 255};
        spots[2] = '{128, 128};
        spots[3] = '{192, 1};
        spots[4] = '{224, 38};
        spots[5] = '{256, 128};

        s2exp = '{128, 255, 128, 1, 128, 255, 128, 1};

        // reset for three clocks, then first samples
        for (int i = 0; i < 7; i++) begin
            tick1($sformatf("vec%0d", i), vecs[i].rst, vecs[i].exp);
            if (i >= 3)
                samp[i-3] = int'(data1);
        end

        // one full period plus the wrap sample
        for (int k = 4; k <= 256; k++) begin
            tick1($sformatf("run k=%0d", k), 1'b0, s_ref(k % 256));
            samp[k] = int'(data1);
        end

        for (int i = 0; i < 6; i++)
            check($sformatf("spot k=%0d", spots[i].k),
                  samp[spots[i].k], spots[i].exp);

        // mid-waveform reset at k = 100
        tick1("rst2", 1'b1, 128);
        for (int k = 0; k < 100; k++)
            tick1($sformatf("pre k=%0d", k), 1'b0, s_ref(k));
        tick1("midrst", 1'b1, 128);
        tick1("restart0", 1'b0, 128);
        tick1("restart1", 1'b0, 131);
        tick1("restart2", 1'b0, 134);

        // STEP = 64 instance
        tick2("s64 rst", 1'b1, 128);
        for (int i = 0; i < 8; i++)
            tick2($sformatf("s64 n=%0d", i), 1'b0, s2exp[i]);

        // exhaustive table sweep
        for (int k = 0; k < 256; k++) begin
            rbus.idx = 8'(k);
            #1;
            check($sformatf("rom k=%0d", k),
                  int'(rbus.sample), s_ref(k));
            check($sformatf("rom range k=%0d", k),
                  int'(rbus.sample >= 8'd1 && rbus.sample <= 8'd255),
                  1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
